// File: rtl/mips_muldiv_unit.sv
// MIPS HI/LO multiply-divide unit: 33-cycle iterative MULT/MULTU/DIV/DIVU
// with MTHI/MTLO write access while idle.
module mips_muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t      state_r;
    logic [1:0]  op_r;
    logic [31:0] mag_a_r;
    logic [31:0] mag_b_r;
    logic        sign_a_r;
    logic        sign_b_r;
    logic [5:0]  cnt_r;
    logic [63:0] acc_r;

    logic [32:0] mul_sum_s;
    logic [64:0] div_shift_s;
    logic [32:0] div_trial_s;
    logic [63:0] acc_next_s;
    logic        neg_s;
    logic [63:0] prod_s;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [31:0] orig_a_s;
    logic [31:0] res_hi_s;
    logic [31:0] res_lo_s;
    logic        sgn_a_s;
    logic        sgn_b_s;
    logic [31:0] in_mag_a_s;
    logic [31:0] in_mag_b_s;

    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

    // Operand magnitudes and sign flags captured on an accepted start
    always_comb begin
        sgn_a_s    = ~op[0] & operand_a[31];
        sgn_b_s    = ~op[0] & operand_b[31];
        in_mag_a_s = abs32(operand_a, ~op[0]);
        in_mag_b_s = abs32(operand_b, ~op[0]);
    end

    // One shift-add (multiply) or restoring shift-subtract (divide) step.
    // Multiply keeps the multiplier in acc[31:0]; divide keeps {remainder, quotient}.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, mag_a_r} : 33'd0);
        div_shift_s = {acc_r, 1'b0};
        div_trial_s = div_shift_s[64:32] - {1'b0, mag_b_r};
        acc_next_s  = acc_r;
        if (op_r[1]) begin
            if (div_trial_s[32]) begin
                acc_next_s = div_shift_s[63:0];
            end else begin
                acc_next_s = {div_trial_s[31:0], div_shift_s[31:1], 1'b1};
            end
        end else begin
            acc_next_s = {mul_sum_s, acc_r[31:1]};
        end
    end

    // Sign correction and divide-by-zero override of the final accumulator
    always_comb begin
        neg_s    = sign_a_r ^ sign_b_r;
        prod_s   = neg_s ? (64'd0 - acc_r) : acc_r;
        quot_s   = neg_s ? (32'd0 - acc_r[31:0]) : acc_r[31:0];
        rem_s    = sign_a_r ? (32'd0 - acc_r[63:32]) : acc_r[63:32];
        orig_a_s = sign_a_r ? (32'd0 - mag_a_r) : mag_a_r;
        if (!op_r[1]) begin
            res_hi_s = prod_s[63:32];
            res_lo_s = prod_s[31:0];
        end else if (mag_b_r == 32'd0) begin
            res_hi_s = orig_a_s;
            res_lo_s = 32'hFFFF_FFFF;
        end else begin
            res_hi_s = rem_s;
            res_lo_s = quot_s;
        end
    end

    // Control FSM, datapath registers and HI/LO architectural state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            op_r     <= 2'd0;
            mag_a_r  <= 32'd0;
            mag_b_r  <= 32'd0;
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
            cnt_r    <= 6'd0;
            acc_r    <= 64'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        op_r     <= op;
                        mag_a_r  <= in_mag_a_s;
                        mag_b_r  <= in_mag_b_s;
                        sign_a_r <= sgn_a_s;
                        sign_b_r <= sgn_b_s;
                        cnt_r    <= 6'd0;
                        acc_r    <= {32'd0, (op[1] ? in_mag_a_s : in_mag_b_s)};
                        busy     <= 1'b1;
                        state_r  <= RUN;
                    end else begin
                        if (hi_we) begin
                            hi <= wr_data;
                        end
                        if (lo_we) begin
                            lo <= wr_data;
                        end
                    end
                end
                RUN: begin
                    acc_r <= acc_next_s;
                    cnt_r <= cnt_r + 6'd1;
                    if (cnt_r == 6'd31) begin
                        state_r <= FINISH;
                    end
                end
                FINISH: begin
                    hi      <= res_hi_s;
                    lo      <= res_lo_s;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit: arithmetic reference model checked
// every cycle, plus directed scenarios with hand-computed results.
module tb_mips_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    mips_muldiv_unit dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b),
        .hi_we(hi_we), .lo_we(lo_we), .wr_data(wr_data),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference result {hi, lo} from plain arithmetic
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = 64'd0;
        case (o)
            2'b00: p = sa * sb;
            2'b01: p = ua * ub;
            2'b10: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    // Model: remaining-latency countdown plus pending result
    int          m_cnt  = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi   = 32'd0;
    logic [31:0] m_lo   = 32'd0;
    logic [63:0] m_pend = 64'd0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_hi   <= m_pend[63:32];
                    m_lo   <= m_pend[31:0];
                    m_done <= 1'b1;
                end
            end else if (start) begin
                m_pend <= ref_result(op, operand_a, operand_b);
                m_cnt  <= 33;
            end else begin
                if (hi_we) m_hi <= wr_data;
                if (lo_we) m_lo <= wr_data;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy", {63'd0, busy}, {63'd0, (m_cnt != 0)});
            check("cyc_done", {63'd0, done}, {63'd0, m_done});
            check("cyc_hi", {32'd0, hi}, {32'd0, m_hi});
            check("cyc_lo", {32'd0, lo}, {32'd0, m_lo});
        end
    end

    // Launch one op (caller at a negedge); hold keeps start high and pokes MTHI mid-run
    task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input bit hold);
        int  bcnt;
        bit  got;
        bcnt      = 0;
        got       = 1'b0;
        start     = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (!hold || i == 20) start = 1'b0;
            if (hold && i == 9) begin
                hi_we   = 1'b1;
                wr_data = 32'h0000_ABCD;
            end
            if (hold && i == 10) hi_we = 1'b0;
            if (busy) bcnt++;
            if (done) got = 1'b1;
        end
        start = 1'b0;
        hi_we = 1'b0;
        check({nm, "_done_seen"}, {63'd0, got}, 64'd1);
        check({nm, "_hi"}, {32'd0, hi}, {32'd0, eh});
        check({nm, "_lo"}, {32'd0, lo}, {32'd0, el});
        check({nm, "_busy_cycles"}, 64'(bcnt), 64'd33);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        op        = 2'b00;
        operand_a = 32'd0;
        operand_b = 32'd0;
        hi_we     = 1'b0;
        lo_we     = 1'b0;
        wr_data   = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        rst    = 1'b0;
        chk_en = 1'b1;

        run_op("mult_neg3x7",  2'b00, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op("multu_max",    2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("mult_min_sq",  2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
        run_op("mult_by_m1",   2'b00, 32'h1234_5678, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hEDCB_A988, 1'b0);
        run_op("div_neg7_2",   2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_ovf",      2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        run_op("div_100_m7",   2'b10, 32'd100,       32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, 1'b0);
        run_op("div_m100_m7",  2'b10, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_000E, 1'b0);
        run_op("div_by0",      2'b10, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0);
        run_op("divu_by0",     2'b11, 32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF, 1'b0);
        run_op("divu_big",     2'b11, 32'hFFFF_FFFF, 32'h10,       32'h0000_000F, 32'h0FFF_FFFF, 1'b0);
        run_op("held_start",   2'b01, 32'd6,         32'd7,        32'h0000_0000, 32'h0000_002A, 1'b1);
        repeat (3) @(negedge clk);
        check("no_requeue", {63'd0, busy}, 64'd0);

        hi_we   = 1'b1;
        wr_data = 32'h0000_ABCD;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi", {32'd0, hi}, 64'h0000_ABCD);
        lo_we   = 1'b1;
        hi_we   = 1'b1;
        wr_data = 32'h1357_2468;
        @(negedge clk);
        lo_we = 1'b0;
        hi_we = 1'b0;
        check("mt_both_hi", {32'd0, hi}, 64'h1357_2468);
        check("mt_both_lo", {32'd0, lo}, 64'h1357_2468);

        start     = 1'b1;
        op        = 2'b01;
        operand_a = 32'd2;
        operand_b = 32'd3;
        hi_we     = 1'b1;
        wr_data   = 32'h0000_FFFF;
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        check("start_wins_hi", {32'd0, hi}, 64'h1357_2468);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_hi", {32'd0, hi}, 64'd0);
        check("midrst_lo", {32'd0, lo}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        rst = 1'b0;
        run_op("multu_3x5", 2'b01, 32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F, 1'b0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mips_muldiv_unit.md
MIPS_MULDIV_UNIT -- requirements
Module: mips_muldiv_unit

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous reset, active-high.
REQ-005 start  in  1  request to begin an operation; sampled on the clock edge.
REQ-006 op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 operand_a  in  32  rs value (register-file read_data_1); the dividend for DIV/DIVU.
REQ-008 operand_b  in  32  rt value (register-file read_data_2); the divisor for DIV/DIVU.
REQ-009 hi_we  in  1  MTHI write enable.
REQ-010 lo_we  in  1  MTLO write enable.
REQ-011 wr_data  in  32  MTHI/MTLO data.
REQ-012 busy  out  1  high while an operation is in progress.
REQ-013 done  out  1  one-cycle pulse when a result is committed.
REQ-014 hi  out  32  HI register (MFHI source).
REQ-015 lo  out  32  LO register (MFLO source).

Function
REQ-016 The block SHALL implement an FSM with the states IDLE, RUN and FINISH.
REQ-017 In IDLE, start=1 at edge E0 SHALL latch op, the operand magnitudes and the sign flags, clear a 6-bit iteration counter, and enter RUN.
REQ-018 RUN SHALL perform one iteration per edge, E1..E32, then enter FINISH.
  - Multiply: radix-2 shift-add on the magnitudes into a 64-bit accumulator.
  - Divide: restoring shift-subtract on the magnitudes.
REQ-019 At edge E33 (the FINISH edge), the block SHALL apply sign correction, write hi/lo, assert done for the following cycle, and return to IDLE.
REQ-020 busy SHALL be 1 for exactly 33 cycles, from E0 to E33, and 0 otherwise; it SHALL be registered, not combinational from start.
REQ-021 MULT/MULTU SHALL produce {hi,lo} = the full 64-bit product.
  - MULT: the product SHALL be negated when exactly one operand is negative.
  - MULTU: the operands SHALL be treated as unsigned.
REQ-022 DIV/DIVU SHALL produce lo = quotient and hi = remainder.
  - DIV: the quotient SHALL truncate toward zero.
  - DIV: the quotient SHALL be negated when the operand signs differ.
  - DIV: the remainder SHALL take the sign of the dividend.
REQ-023 Divide by zero (either signedness) SHALL give lo=32'hFFFFFFFF and hi=operand_a, with the same 33-cycle latency.
REQ-024 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL give lo=32'h80000000 and hi=0, with no trap.
REQ-025 start while busy=1 SHALL be ignored; no queuing.
REQ-026 hi_we/lo_we while busy=1 SHALL be ignored.
REQ-027 hi_we/lo_we in IDLE SHALL update hi/lo at that edge; both may write in the same cycle.
REQ-028 If start and hi_we/lo_we are asserted in the same IDLE cycle, start SHALL win and the writes SHALL be dropped.
REQ-029 hi/lo SHALL hold their values between writes and during RUN; no intermediate values SHALL be visible.
REQ-030 done SHALL be 0 in every cycle other than the one following E33.

Reset
REQ-031 rst=1 SHALL immediately force:
  - state=IDLE
  - busy=0
  - done=0
  - hi=0, lo=0
  - counter and accumulators cleared
REQ-032 Reset mid-operation SHALL abandon the operation; no result SHALL be committed and done SHALL not pulse.
REQ-033 A start on the first edge after rst deasserts SHALL be accepted.

Verification
REQ-034 Scenario: MULT a=32'hFFFFFFFD (-3), b=7 -> after E33: hi=FFFFFFFF, lo=FFFFFFEB, done pulse 1 cycle.
REQ-035 Scenario: MULTU a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
REQ-036 Scenario: DIV a=FFFFFFF9 (-7), b=2 -> lo=FFFFFFFD, hi=FFFFFFFF; then DIV 80000000/FFFFFFFF -> lo=80000000, hi=0.
REQ-037 Scenario: DIVU a=00001234, b=0 -> hi=00001234, lo=FFFFFFFF.
REQ-038 Scenario: start held while busy, plus hi_we=1 with wr_data=0000ABCD at cycle 10 of RUN -> one result only, HI write ignored, busy high for exactly 33 cycles; MTHI in IDLE -> hi=0000ABCD next cycle.
REQ-039 Scenario: rst pulsed at RUN cycle 15 -> busy=0, hi=lo=0, no done pulse; a fresh MULTU 3*5 then gives lo=0000000F, hi=0.
